// File: rtl/game_round_ctrl.sv
// Round sequencer for the whack-a-mole game: IDLE -> COUNTDOWN -> PLAYING -> GAME_OVER,
// with a ms/second timebase, per-round hit counting and a best-round high score.
module game_round_ctrl #(
    parameter int CLKS_PER_MS = 50000,
    parameter int COUNTDOWN_S = 3,
    parameter int ROUND_S     = 30
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start_pulse,
    input  logic        mole_hit,
    output logic [1:0]  game_state,
    output logic        game_active,
    output logic        score_clear,
    output logic [6:0]  seconds_left,
    output logic [10:0] round_score,
    output logic [10:0] high_score,
    output logic        new_high
);

    localparam int PW = (CLKS_PER_MS > 1) ? $clog2(CLKS_PER_MS) : 1;

    typedef enum logic [1:0] {
        IDLE      = 2'b00,
        COUNTDOWN = 2'b01,
        PLAYING   = 2'b10,
        GAME_OVER = 2'b11
    } state_t;

    state_t        state;
    logic [PW-1:0] presc;
    logic [9:0]    ms_cnt;
    logic          running;
    logic          presc_wrap;
    logic          sec_tick;
    logic [10:0]   score_next;

    assign running    = (state == COUNTDOWN) || (state == PLAYING);
    assign presc_wrap = (presc == PW'(CLKS_PER_MS - 1));
    assign sec_tick   = running && presc_wrap && (ms_cnt == 10'd999);
    assign game_state = state;

    // Saturating hit count; also feeds the high-score compare so a hit on the final tick counts.
    always_comb begin
        score_next = round_score;
        if (mole_hit && (round_score != 11'h7FF))
            score_next = round_score + 11'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            game_active  <= 1'b0;
            score_clear  <= 1'b0;
            seconds_left <= 7'd0;
            round_score  <= 11'd0;
            high_score   <= 11'd0;
            new_high     <= 1'b0;
            presc        <= '0;
            ms_cnt       <= 10'd0;
        end else begin
            score_clear <= 1'b0;

            if (running) begin
                if (presc_wrap) begin
                    presc  <= '0;
                    ms_cnt <= (ms_cnt == 10'd999) ? 10'd0 : ms_cnt + 10'd1;
                end else begin
                    presc <= presc + 1'b1;
                end
            end

            // A start request from any state (re)starts the countdown and wins over the final tick.
            if (start_pulse) begin
                state        <= COUNTDOWN;
                game_active  <= 1'b0;
                seconds_left <= 7'(COUNTDOWN_S);
                round_score  <= 11'd0;
                score_clear  <= 1'b1;
                new_high     <= 1'b0;
                presc        <= '0;
                ms_cnt       <= 10'd0;
            end else begin
                case (state)
                    COUNTDOWN: begin
                        if (sec_tick) begin
                            if (seconds_left > 7'd1) begin
                                seconds_left <= seconds_left - 7'd1;
                            end else begin
                                state        <= PLAYING;
                                game_active  <= 1'b1;
                                seconds_left <= 7'(ROUND_S);
                                presc        <= '0;
                                ms_cnt       <= 10'd0;
                            end
                        end
                    end
                    PLAYING: begin
                        round_score <= score_next;
                        if (sec_tick) begin
                            if (seconds_left > 7'd1) begin
                                seconds_left <= seconds_left - 7'd1;
                            end else begin
                                state        <= GAME_OVER;
                                game_active  <= 1'b0;
                                seconds_left <= 7'd0;
                                if (score_next > high_score) begin
                                    high_score <= score_next;
                                    new_high   <= 1'b1;
                                end
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_game_round_ctrl.sv
// Directed bench for game_round_ctrl with a fast timebase (1 s = 2000 clk cycles).
module tb_game_round_ctrl;

    logic        clk;
    logic        reset;
    logic        start_pulse;
    logic        mole_hit;
    logic [1:0]  game_state;
    logic        game_active;
    logic        score_clear;
    logic [6:0]  seconds_left;
    logic [10:0] round_score;
    logic [10:0] high_score;
    logic        new_high;

    int n_checks = 0;
    int n_fail   = 0;

    game_round_ctrl #(
        .CLKS_PER_MS(2),
        .COUNTDOWN_S(3),
        .ROUND_S    (5)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start_pulse (start_pulse),
        .mole_hit    (mole_hit),
        .game_state  (game_state),
        .game_active (game_active),
        .score_clear (score_clear),
        .seconds_left(seconds_left),
        .round_score (round_score),
        .high_score  (high_score),
        .new_high    (new_high)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        start;
        logic        hit;
        int          idle;
        logic [1:0]  st;
        logic [6:0]  sl;
        logic        sc;
        logic        ga;
        logic [10:0] rs;
        logic [10:0] hs;
        logic        nh;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mkv(logic r, logic s, logic h, int idle, logic [1:0] st, logic [6:0] sl,
                                 logic sc, logic ga, logic [10:0] rs, logic [10:0] hs, logic nh);
        vec_t v;
        v.rst = r; v.start = s; v.hit = h; v.idle = idle;
        v.st = st; v.sl = sl; v.sc = sc; v.ga = ga; v.rs = rs; v.hs = hs; v.nh = nh;
        return v;
    endfunction

    task automatic chk(string tag, string what, int act, int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s.%s: got %0d expected %0d", tag, what, act, exp);
        end
    endtask

    task automatic expect_out(string tag, logic [1:0] st, logic [6:0] sl, logic sc, logic ga,
                              logic [10:0] rs, logic [10:0] hs, logic nh);
        chk(tag, "game_state",   int'(game_state),   int'(st));
        chk(tag, "seconds_left", int'(seconds_left), int'(sl));
        chk(tag, "score_clear",  int'(score_clear),  int'(sc));
        chk(tag, "game_active",  int'(game_active),  int'(ga));
        chk(tag, "round_score",  int'(round_score),  int'(rs));
        chk(tag, "high_score",   int'(high_score),   int'(hs));
        chk(tag, "new_high",     int'(new_high),     int'(nh));
    endtask

    // Drive inputs for exactly one rising edge; called and returns on a falling edge.
    task automatic pulse(logic r, logic s, logic h);
        reset = r; start_pulse = s; mole_hit = h;
        @(negedge clk);
        reset = 1'b0; start_pulse = 1'b0; mole_hit = 1'b0;
    endtask

    task automatic idle(int n);
        repeat (n) @(negedge clk);
    endtask

    // Full round from a start request: 6000 cycles of countdown, nhits, then 10000 cycles of play.
    task automatic run_round(string tag, int nhits, logic [10:0] prev_hs, logic [10:0] exp_hs, logic exp_nh);
        pulse(1'b0, 1'b1, 1'b0);
        expect_out({tag, "_start"}, 2'b01, 7'd3, 1'b1, 1'b0, 11'd0, prev_hs, 1'b0);
        idle(6000);
        expect_out({tag, "_play"}, 2'b10, 7'd5, 1'b0, 1'b1, 11'd0, prev_hs, 1'b0);
        for (int i = 0; i < nhits; i++) pulse(1'b0, 1'b0, 1'b1);
        idle(10000 - nhits);
        expect_out({tag, "_over"}, 2'b11, 7'd0, 1'b0, 1'b0, 11'(nhits), exp_hs, exp_nh);
    endtask

    initial begin
        reset = 1'b1; start_pulse = 1'b0; mole_hit = 1'b0;
        idle(2);

        // Round 1: reset state, countdown timing, 7 hits, game over with a new high score.
        vecs.push_back(mkv(1, 0, 0, 0,    2'b00, 7'd0, 0, 0, 11'd0, 11'd0, 0));
        vecs.push_back(mkv(0, 1, 0, 0,    2'b01, 7'd3, 1, 0, 11'd0, 11'd0, 0));
        vecs.push_back(mkv(0, 0, 0, 0,    2'b01, 7'd3, 0, 0, 11'd0, 11'd0, 0));
        vecs.push_back(mkv(0, 0, 0, 1997, 2'b01, 7'd3, 0, 0, 11'd0, 11'd0, 0));
        vecs.push_back(mkv(0, 0, 0, 0,    2'b01, 7'd2, 0, 0, 11'd0, 11'd0, 0));
        vecs.push_back(mkv(0, 0, 0, 3998, 2'b01, 7'd1, 0, 0, 11'd0, 11'd0, 0));
        vecs.push_back(mkv(0, 0, 0, 0,    2'b10, 7'd5, 0, 1, 11'd0, 11'd0, 0));
        for (int i = 1; i <= 7; i++)
            vecs.push_back(mkv(0, 0, 1, 0, 2'b10, 7'd5, 0, 1, 11'(i), 11'd0, 0));
        vecs.push_back(mkv(0, 0, 0, 9991, 2'b10, 7'd1, 0, 1, 11'd7, 11'd0, 0));
        vecs.push_back(mkv(0, 0, 0, 0,    2'b11, 7'd0, 0, 0, 11'd7, 11'd7, 1));
        vecs.push_back(mkv(0, 0, 1, 0,    2'b11, 7'd0, 0, 0, 11'd7, 11'd7, 1));
        vecs.push_back(mkv(0, 0, 0, 50,   2'b11, 7'd0, 0, 0, 11'd7, 11'd7, 1));

        foreach (vecs[i]) begin
            pulse(vecs[i].rst, vecs[i].start, vecs[i].hit);
            idle(vecs[i].idle);
            expect_out($sformatf("vec%0d", i), vecs[i].st, vecs[i].sl, vecs[i].sc, vecs[i].ga,
                       vecs[i].rs, vecs[i].hs, vecs[i].nh);
        end

        // Restart mid-PLAYING with 9 hits: score cleared, high score untouched.
        pulse(1'b0, 1'b1, 1'b0);
        idle(6000);
        for (int i = 0; i < 9; i++) pulse(1'b0, 1'b0, 1'b1);
        expect_out("mid_pre", 2'b10, 7'd5, 1'b0, 1'b1, 11'd9, 11'd7, 1'b0);
        pulse(1'b0, 1'b1, 1'b0);
        expect_out("mid_restart", 2'b01, 7'd3, 1'b1, 1'b0, 11'd0, 11'd7, 1'b0);
        pulse(1'b0, 1'b0, 1'b0);
        expect_out("mid_clear_once", 2'b01, 7'd3, 1'b0, 1'b0, 11'd0, 11'd7, 1'b0);

        // Lower round, then a tie: neither sets new_high.
        run_round("r2", 4, 11'd7, 11'd7, 1'b0);
        run_round("r3", 7, 11'd7, 11'd7, 1'b0);

        // Hit on the final tick is counted.
        pulse(1'b0, 1'b1, 1'b0);
        idle(6000);
        pulse(1'b0, 1'b0, 1'b1);
        pulse(1'b0, 1'b0, 1'b1);
        idle(9997);
        expect_out("fhit_pre", 2'b10, 7'd1, 1'b0, 1'b1, 11'd2, 11'd7, 1'b0);
        pulse(1'b0, 1'b0, 1'b1);
        expect_out("fhit_over", 2'b11, 7'd0, 1'b0, 1'b0, 11'd3, 11'd7, 1'b0);

        // Restart during COUNTDOWN re-zeroes the timebase; saturation; start on the final tick wins.
        pulse(1'b0, 1'b1, 1'b0);
        idle(100);
        expect_out("cd_mid", 2'b01, 7'd3, 1'b0, 1'b0, 11'd0, 11'd7, 1'b0);
        pulse(1'b0, 1'b1, 1'b0);
        expect_out("cd_restart", 2'b01, 7'd3, 1'b1, 1'b0, 11'd0, 11'd7, 1'b0);
        idle(5999);
        expect_out("cd_last", 2'b01, 7'd1, 1'b0, 1'b0, 11'd0, 11'd7, 1'b0);
        idle(1);
        expect_out("cd_play", 2'b10, 7'd5, 1'b0, 1'b1, 11'd0, 11'd7, 1'b0);
        for (int i = 0; i < 2050; i++) pulse(1'b0, 1'b0, 1'b1);
        expect_out("sat", 2'b10, 7'd4, 1'b0, 1'b1, 11'd2047, 11'd7, 1'b0);
        idle(7949);
        expect_out("fstart_pre", 2'b10, 7'd1, 1'b0, 1'b1, 11'd2047, 11'd7, 1'b0);
        pulse(1'b0, 1'b1, 1'b0);
        expect_out("fstart", 2'b01, 7'd3, 1'b1, 1'b0, 11'd0, 11'd7, 1'b0);

        // Reset in PLAYING clears everything; hits in IDLE are ignored.
        idle(6000);
        pulse(1'b0, 1'b0, 1'b1);
        expect_out("rst_pre", 2'b10, 7'd5, 1'b0, 1'b1, 11'd1, 11'd7, 1'b0);
        pulse(1'b1, 1'b0, 1'b1);
        expect_out("rst", 2'b00, 7'd0, 1'b0, 1'b0, 11'd0, 11'd0, 1'b0);
        pulse(1'b0, 1'b0, 1'b1);
        idle(3);
        expect_out("idle_hit", 2'b00, 7'd0, 1'b0, 1'b0, 11'd0, 11'd0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/game_round_ctrl.md
GAME_ROUND_CTRL -- requirements
Module: game_round_ctrl

Interface
REQ-001 Parameter CLKS_PER_MS, default 50000: clk cycles per millisecond.
REQ-002 Parameter COUNTDOWN_S, default 3: pre-round countdown in seconds, range 1..9.
REQ-003 Parameter ROUND_S, default 30: round length in seconds, range 1..99.
REQ-004 clk  input  1: single system clock; all logic on its rising edge.
REQ-005 reset  input  1: synchronous, active-high reset.
REQ-006 start_pulse  input  1: one-cycle start/restart request, already debounced and edge-detected.
REQ-007 mole_hit  input  1: one-cycle successful-hit pulse from the hit-detection stage.
REQ-008 game_state  output  2: 00 IDLE, 01 COUNTDOWN, 10 PLAYING, 11 GAME_OVER.
REQ-009 game_active  output  1: high only in PLAYING; gates mole spawning and hit detection downstream.
REQ-010 score_clear  output  1: one-cycle pulse instructing the score counter to zero.
REQ-011 seconds_left  output  7: remaining seconds of the current COUNTDOWN or PLAYING phase; 0 otherwise.
REQ-012 round_score  output  11: hits counted in the current or most recent round.
REQ-013 high_score  output  11: best round_score since reset.
REQ-014 new_high  output  1: high from the GAME_OVER entry that set a new high_score until the next start_pulse or reset.

Function
REQ-015 Prescaler SHALL count 0..CLKS_PER_MS-1 and a ms counter 0..999; sec_tick SHALL pulse one cycle when both wrap together.
REQ-016 Prescaler and ms counter SHALL run only in COUNTDOWN and PLAYING and SHALL be zeroed on every entry to COUNTDOWN or PLAYING, so each phase second is exactly 1000*CLKS_PER_MS cycles.
REQ-017 IDLE: start_pulse -> COUNTDOWN next cycle; seconds_left := COUNTDOWN_S; round_score := 0; score_clear pulses in that same next cycle.
REQ-018 COUNTDOWN: sec_tick with seconds_left > 1 -> decrement; sec_tick with seconds_left == 1 -> PLAYING, seconds_left := ROUND_S.
REQ-019 PLAYING: mole_hit increments round_score, saturating at 2047; sec_tick with seconds_left > 1 -> decrement; sec_tick with seconds_left == 1 -> GAME_OVER, seconds_left := 0.
REQ-020 mole_hit coincident with the final sec_tick SHALL be counted and included in the high-score comparison.
REQ-021 On entry to GAME_OVER: if final round_score > high_score, high_score := final round_score and new_high := 1; on a tie, high_score and new_high unchanged.
REQ-022 GAME_OVER: state held, round_score frozen, mole_hit ignored; start_pulse -> COUNTDOWN with the REQ-017 actions, new_high := 0.
REQ-023 start_pulse in COUNTDOWN or PLAYING SHALL restart: -> COUNTDOWN with the REQ-017 actions; the aborted round SHALL NOT update high_score.
REQ-024 mole_hit outside PLAYING SHALL be ignored.
REQ-025 start_pulse coincident with the final sec_tick in PLAYING: restart wins; no GAME_OVER, no high_score update.
REQ-026 All outputs SHALL be registered; game_active and game_state SHALL change in the same cycle as the state register.

Reset
REQ-027 reset SHALL force IDLE, seconds_left=0, round_score=0, high_score=0, new_high=0, score_clear=0, game_active=0, prescaler and ms counter 0, taking priority over all inputs, including mid-round.

Verification (CLKS_PER_MS=2, COUNTDOWN_S=3, ROUND_S=5; 1 s = 2000 cycles)
REQ-028 reset, then start_pulse -> next cycle state=01, seconds_left=3, score_clear=1 for exactly 1 cycle; after 6000 cycles state=10, seconds_left=5, game_active=1.
REQ-029 7 mole_hit pulses during PLAYING, run to end -> state=11 after 5*2000 cycles in PLAYING, round_score=7, high_score=7, new_high=1; further mole_hit leaves round_score=7.
REQ-030 Second round with 4 hits -> high_score stays 7, new_high=0; third round with 7 hits (tie) -> new_high=0.
REQ-031 start_pulse mid-PLAYING with round_score=9 -> state=01, round_score=0, score_clear pulse, high_score unchanged.
REQ-032 mole_hit on the final sec_tick cycle with round_score=2 -> GAME_OVER with round_score=3; separately, start_pulse on the final tick -> state=01, no high_score update.
REQ-033 reset asserted in PLAYING with high_score=7 -> all outputs 0, state=00 next cycle; mole_hit while IDLE -> round_score stays 0.
